// File: rtl/shift_down_stage.sv
// rtl/shift_down_stage.sv - one-register shift-down stage that passes, captures or holds an instruction
module shift_down_stage #(
  parameter logic [4:0]  SMC_ID            = 5'd0,
  parameter int unsigned PARAM_UR_WORD_CNT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [133:0] crd_shiftdn_in,
  input  logic [127:0] dvr_shiftdn_in,
  output logic [133:0] crd_shiftdn_out
);

  // Unified-register word count is carried for configuration compatibility only.
  if (PARAM_UR_WORD_CNT == 0) begin : g_ur_word_cnt_reserved
  end

  typedef enum logic [1:0] {
    ACT_HOLD    = 2'd0,
    ACT_PASS    = 2'd1,
    ACT_CAPTURE = 2'd2
  } act_e;

  logic         in_vld;
  logic [4:0]   in_id;
  act_e         act;
  logic [133:0] out_d;
  logic [133:0] out_q;

  assign in_vld = crd_shiftdn_in[133];
  assign in_id  = crd_shiftdn_in[4:0];

  // Classify the incoming instruction against this stage's id (unsigned compare).
  always_comb begin
    act = ACT_HOLD;
    if (in_vld) begin
      if (in_id > SMC_ID) begin
        act = ACT_PASS;
      end else if (in_id == SMC_ID) begin
        act = ACT_CAPTURE;
      end
    end
  end

  // Next register value: forward, replace payload with local data, or keep.
  always_comb begin
    out_d = out_q;
    case (act)
      ACT_PASS:    out_d = crd_shiftdn_in;
      ACT_CAPTURE: out_d = {1'b1, dvr_shiftdn_in, SMC_ID};
      default:     out_d = out_q;
    endcase
  end

  // Output register; reset wins over every instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign crd_shiftdn_out = out_q;

endmodule

// File: tb/tb_shift_down_stage.sv
// tb/tb_shift_down_stage.sv - vector table plus random scoreboard bench for shift_down_stage
module tb_shift_down_stage;

  localparam logic [4:0] SID = 5'd3;

  logic         clk = 1'b0;
  logic         rst;
  logic [133:0] crd_in;
  logic [127:0] dvr;
  logic [133:0] crd_out;

  always #5 clk = ~clk;

  shift_down_stage #(
    .SMC_ID(SID),
    .PARAM_UR_WORD_CNT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .crd_shiftdn_in(crd_in),
    .dvr_shiftdn_in(dvr),
    .crd_shiftdn_out(crd_out)
  );

  typedef struct {
    logic         rst;
    logic [133:0] cin;
    logic [127:0] dvr;
    logic [133:0] exp;
  } vec_t;

  vec_t         vecs[$];
  logic [133:0] sb_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;

  function automatic logic [133:0] ins(input logic v, input logic [127:0] d, input logic [4:0] id);
    return {v, d, id};
  endfunction

  function automatic logic [133:0] model(input logic [133:0] prev, input logic r,
                                         input logic [133:0] cin, input logic [127:0] d);
    if (r) return '0;
    if (!cin[133]) return prev;
    if (cin[4:0] == SID) return {1'b1, d, SID};
    if (cin[4:0] > SID) return cin;
    return prev;
  endfunction

  task automatic add(input logic r, input logic [133:0] cin, input logic [127:0] d, input logic [133:0] e);
    vec_t v;
    v.rst = r;
    v.cin = cin;
    v.dvr = d;
    v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [133:0] act, input logic [133:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input string name, input logic r, input logic [133:0] cin,
                      input logic [127:0] d, input logic [133:0] e);
    logic [133:0] exp_v;
    rst    = r;
    crd_in = cin;
    dvr    = d;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty got %h expected entry", name, crd_out);
    end else begin
      exp_v = sb_q.pop_front();
      check(name, crd_out, exp_v);
    end
  endtask

  logic [127:0] a5, b6, ff, p1234, cafe, ones, twos, threes, bad0;
  logic [127:0] f4, f5, f6, f7, f8, f9, fb, fc, fd;
  logic [133:0] last, e, cin_r;
  logic [127:0] dvr_r;
  logic         rst_r;

  initial begin
    a5     = {16{8'hA5}};
    b6     = {16{8'hB6}};
    ff     = {32{4'hF}};
    p1234  = {2{64'h1234_5678_9ABC_DEF0}};
    cafe   = {4{32'hCAFE_BABE}};
    ones   = {32{4'h1}};
    twos   = {32{4'h2}};
    threes = {32{4'h3}};
    bad0   = {8{16'hBAD0}};
    f4     = {32{4'h4}};
    f5     = {32{4'h5}};
    f6     = {32{4'h6}};
    f7     = {32{4'h7}};
    f8     = {32{4'h8}};
    f9     = {32{4'h9}};
    fb     = {32{4'hB}};
    fc     = {32{4'hC}};
    fd     = {32{4'hD}};

    // reset, then holds keep zero
    add(1'b1, ins(1'b1, a5, 5'd4), p1234, '0);
    add(1'b1, ins(1'b1, b6, 5'd3), cafe,  '0);
    add(1'b0, ins(1'b0, ff, 5'd4), cafe,  '0);
    add(1'b0, ins(1'b1, ff, 5'd2), cafe,  '0);
    add(1'b0, ins(1'b0, ff, 5'd3), cafe,  '0);
    // pass
    add(1'b0, ins(1'b1, a5, 5'd4), cafe,  ins(1'b1, a5, 5'd4));
    add(1'b0, ins(1'b1, b6, 5'd5), cafe,  ins(1'b1, b6, 5'd5));
    // capture
    add(1'b0, ins(1'b1, ff, 5'd3), p1234, ins(1'b1, p1234, 5'd3));
    add(1'b0, ins(1'b1, ff, 5'd3), cafe,  ins(1'b1, cafe, 5'd3));
    // hold below
    add(1'b0, ins(1'b1, ff, 5'd3), ones,  ins(1'b1, ones, 5'd3));
    add(1'b0, ins(1'b1, twos, 5'd2), bad0, ins(1'b1, ones, 5'd3));
    add(1'b0, ins(1'b1, threes, 5'd1), bad0, ins(1'b1, ones, 5'd3));
    // mixed
    add(1'b0, ins(1'b1, f4, 5'd4), bad0,  ins(1'b1, f4, 5'd4));
    add(1'b0, ins(1'b1, ff, 5'd3), f5,    ins(1'b1, f5, 5'd3));
    add(1'b0, ins(1'b1, f7, 5'd2), f6,    ins(1'b1, f5, 5'd3));
    add(1'b0, ins(1'b1, f8, 5'd6), f6,    ins(1'b1, f8, 5'd6));
    // invalid
    add(1'b0, ins(1'b1, ff, 5'd3), f9,    ins(1'b1, f9, 5'd3));
    add(1'b0, ins(1'b0, fb, 5'd3), fd,    ins(1'b1, f9, 5'd3));
    add(1'b0, ins(1'b0, fc, 5'd4), fd,    ins(1'b1, f9, 5'd3));
    // boundaries: top id passes, id 0 holds, reset mid-sequence beats capture
    add(1'b0, ins(1'b1, fd, 5'd31), f9,   ins(1'b1, fd, 5'd31));
    add(1'b0, ins(1'b1, fc, 5'd0), f9,    ins(1'b1, fd, 5'd31));
    add(1'b1, ins(1'b1, ff, 5'd3), f9,    '0);
    add(1'b0, ins(1'b1, fc, 5'd0), f9,    '0);
    add(1'b0, ins(1'b1, fc, 5'd3), fb,    ins(1'b1, fb, 5'd3));

    rst    = 1'b1;
    crd_in = '0;
    dvr    = '0;

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec[%0d]", i), vecs[i].rst, vecs[i].cin, vecs[i].dvr, vecs[i].exp);
    end
    last = vecs[vecs.size() - 1].exp;

    // output must not follow inputs between edges
    crd_in = ins(1'b1, a5, 5'd7);
    dvr    = ones;
    #3;
    check("nocomb_pass", crd_out, last);
    crd_in = ins(1'b1, a5, SID);
    #1;
    check("nocomb_capture", crd_out, last);

    // random traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      rst_r = ($urandom_range(0, 24) == 0);
      dvr_r = {$urandom, $urandom, $urandom, $urandom};
      cin_r = {($urandom_range(0, 3) != 0), $urandom, $urandom, $urandom, $urandom,
               5'($urandom_range(0, 31))};
      e = model(last, rst_r, cin_r, dvr_r);
      step($sformatf("rand[%0d]", i), rst_r, cin_r, dvr_r, e);
      last = e;
      if (i % 16 == 0) begin
        crd_in = ~crd_in;
        dvr    = ~dvr;
        #2;
        check($sformatf("rand_nocomb[%0d]", i), crd_out, last);
      end
    end

    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_drain: got %0d entries left expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
